// File: rtl/avalon_mailbox_fifo_pkg.sv
// Shared constants for the Avalon-MM mailbox FIFO: register map, STATUS/CONTROL
// bit layout, handshake state type and a STATUS word packer.
package avalon_mailbox_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    // Word addresses
    localparam logic [ADDR_W-1:0] REG_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 2'd1;
    localparam logic [ADDR_W-1:0] REG_CTRL    = 2'd2;
    localparam logic [ADDR_W-1:0] REG_SCRATCH = 2'd3;

    // STATUS layout
    localparam int unsigned ST_COUNT_LSB = 0;
    localparam int unsigned ST_COUNT_W   = 16;
    localparam int unsigned ST_EMPTY     = 16;
    localparam int unsigned ST_FULL      = 17;
    localparam int unsigned ST_OVERFLOW  = 18;
    localparam int unsigned ST_UNDERFLOW = 19;
    localparam int unsigned ST_IRQ       = 20;

    // CONTROL layout
    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLEAR   = 1;
    localparam int unsigned CTRL_THR_LSB = 8;
    localparam int unsigned CTRL_THR_MSB = 15;
    localparam int unsigned THR_W        = CTRL_THR_MSB - CTRL_THR_LSB + 1;

    typedef enum logic {
        XFER_IDLE = 1'b0,
        XFER_ACK  = 1'b1
    } xfer_state_t;

    function automatic logic [DATA_W-1:0] pack_status(
        input logic [ST_COUNT_W-1:0] count,
        input logic                  empty,
        input logic                  full,
        input logic                  overflow,
        input logic                  underflow,
        input logic                  irq
    );
        logic [DATA_W-1:0] s;
        s                               = '0;
        s[ST_COUNT_LSB +: ST_COUNT_W]   = count;
        s[ST_EMPTY]                     = empty;
        s[ST_FULL]                      = full;
        s[ST_OVERFLOW]                  = overflow;
        s[ST_UNDERFLOW]                 = underflow;
        s[ST_IRQ]                       = irq;
        return s;
    endfunction

endpackage

// File: rtl/avalon_mailbox_fifo_if.sv
// Avalon-MM slave port bundle (2-bit word address, 32-bit data, waitrequest).
interface avalon_mailbox_fifo_if;
    import avalon_mailbox_pkg::*;

    logic [ADDR_W-1:0] avs_s0_address;
    logic              avs_s0_read;
    logic              avs_s0_write;
    logic [DATA_W-1:0] avs_s0_writedata;
    logic [DATA_W-1:0] avs_s0_readdata;
    logic              avs_s0_waitrequest;

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        input  avs_s0_readdata, avs_s0_waitrequest
    );

    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        output avs_s0_readdata, avs_s0_waitrequest
    );

endinterface

// File: rtl/avalon_mailbox_fifo_sync_fifo.sv
// DEPTH x 32 show-ahead synchronous FIFO; push ignored when full, pop ignored
// when empty, flush returns to the empty state.
module sync_fifo
    import avalon_mailbox_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       head_c,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_d;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/avalon_mailbox_fifo.sv
// Avalon-MM mailbox peripheral: DATA/STATUS/CONTROL/SCRATCH registers over a
// 32-bit FIFO, fixed two-cycle transfers, threshold interrupt.
module avalon_mailbox_fifo
    import avalon_mailbox_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_mailbox_fifo_if.slave  avs,
    output logic                  irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    xfer_state_t       state_q;
    xfer_state_t       state_d;
    logic              req;
    logic              start;
    logic              commit;
    logic              rd_op;
    logic              wr_op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head_c;
    logic [15:0]       count16;

    logic              ctrl_wr;
    logic              scratch_wr;
    logic [THR_W-1:0]  thr_q;
    logic              overflow_q;
    logic              underflow_q;
    logic [DATA_W-1:0] scratch_q;
    logic [DATA_W-1:0] rd_mux_c;

    assign addr  = avs.avs_s0_address;
    assign wd    = avs.avs_s0_writedata;
    assign req   = avs.avs_s0_read | avs.avs_s0_write;
    // Read wins when both strobes are high
    assign rd_op = avs.avs_s0_read;
    assign wr_op = avs.avs_s0_write & ~avs.avs_s0_read;

    // Handshake: first cycle stalls and captures readdata, second cycle commits
    always_ff @(posedge clk) begin
        if (reset) state_q <= XFER_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d                = state_q;
        start                  = 1'b0;
        commit                 = 1'b0;
        avs.avs_s0_waitrequest = reset | req;
        case (state_q)
            XFER_IDLE: begin
                if (req) begin
                    start   = 1'b1;
                    state_d = XFER_ACK;
                end
            end
            XFER_ACK: begin
                avs.avs_s0_waitrequest = reset;
                commit                 = req;
                state_d                = XFER_IDLE;
            end
            default: state_d = XFER_IDLE;
        endcase
    end

    assign fifo_push  = commit & wr_op & (addr == REG_DATA);
    assign fifo_pop   = commit & rd_op & (addr == REG_DATA);
    assign ctrl_wr    = commit & wr_op & (addr == REG_CTRL);
    assign scratch_wr = commit & wr_op & (addr == REG_SCRATCH);
    assign fifo_flush = ctrl_wr & wd[CTRL_FLUSH];
    assign count16    = 16'(fifo_count);

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .flush  (fifo_flush),
        .din    (wd),
        .head_c (fifo_head_c),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        rd_mux_c = '0;
        case (addr)
            REG_DATA:    rd_mux_c = fifo_empty ? '0 : fifo_head_c;
            REG_STATUS:  rd_mux_c = pack_status(count16, fifo_empty, fifo_full,
                                                overflow_q, underflow_q, irq);
            REG_CTRL:    rd_mux_c[CTRL_THR_MSB:CTRL_THR_LSB] = thr_q;
            REG_SCRATCH: rd_mux_c = scratch_q;
            default:     rd_mux_c = '0;
        endcase
    end

    // Register file, sticky flags and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            avs.avs_s0_readdata <= '0;
            overflow_q          <= 1'b0;
            underflow_q         <= 1'b0;
            thr_q               <= '0;
            scratch_q           <= '0;
            irq                 <= 1'b0;
        end else begin
            if (start && rd_op) avs.avs_s0_readdata <= rd_mux_c;
            if (fifo_push && fifo_full) overflow_q <= 1'b1;
            if (fifo_pop && fifo_empty) underflow_q <= 1'b1;
            if (ctrl_wr) begin
                thr_q <= wd[CTRL_THR_MSB:CTRL_THR_LSB];
                if (wd[CTRL_CLEAR]) begin
                    overflow_q  <= 1'b0;
                    underflow_q <= 1'b0;
                end
            end
            if (scratch_wr) scratch_q <= wd;
            irq <= (thr_q != '0) && (count16 >= 16'(thr_q));
        end
    end

endmodule

// File: tb/tb_avalon_mailbox_fifo.sv
// Self-checking bench for avalon_mailbox_fifo: directed register-map scenarios
// followed by randomized traffic against a queue-based reference model.
module tb_avalon_mailbox_fifo;
    import avalon_mailbox_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic irq;

    avalon_mailbox_fifo_if bus ();

    avalon_mailbox_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .avs   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] mq [$];
    logic [7:0]  m_thr;
    logic        m_ovf;
    logic        m_unf;
    logic [31:0] m_scratch;
    logic        exp_irq;

    int n_vec = 0;
    int n_err = 0;

    // Interrupt register value expected in the following cycle
    always @(posedge clk) begin
        if (reset) exp_irq <= 1'b0;
        else       exp_irq <= (m_thr != 8'd0) && (mq.size() >= int'(m_thr));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_thr     = 8'd0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        m_scratch = 32'd0;
    endtask

    function automatic logic [31:0] model_status(input logic irqv);
        int n;
        n = mq.size();
        return {11'd0, irqv, m_unf, m_ovf, (n == int'(DEPTH)), (n == 0), 16'(n)};
    endfunction

    task automatic model_apply(input logic rd, input logic wr, input logic [1:0] a,
                               input logic [31:0] wd);
        if (rd) begin
            if (a == REG_DATA) begin
                if (mq.size() == 0) m_unf = 1'b1;
                else void'(mq.pop_front());
            end
        end else if (wr) begin
            case (a)
                REG_DATA: begin
                    if (mq.size() == int'(DEPTH)) m_ovf = 1'b1;
                    else mq.push_back(wd);
                end
                REG_CTRL: begin
                    if (wd[0]) mq.delete();
                    if (wd[1]) begin
                        m_ovf = 1'b0;
                        m_unf = 1'b0;
                    end
                    m_thr = wd[15:8];
                end
                REG_SCRATCH: m_scratch = wd;
                default: ;
            endcase
        end
    endtask

    // One complete Avalon transfer with handshake, readdata and irq checks
    task automatic xfer(input logic rd, input logic wr, input logic [1:0] a,
                        input logic [31:0] wd, output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic        irq_t;
        int          wc;
        @(negedge clk);
        bus.avs_s0_address   = a;
        bus.avs_s0_read      = rd;
        bus.avs_s0_write     = wr;
        bus.avs_s0_writedata = wd;
        #1;
        irq_t = exp_irq;
        check("wait_first", 32'(bus.avs_s0_waitrequest), 32'd1);
        exp_rd = 32'd0;
        if (rd) begin
            case (a)
                REG_DATA:    if (mq.size() != 0) exp_rd = mq[0];
                REG_STATUS:  exp_rd = model_status(irq_t);
                REG_CTRL:    exp_rd = {16'd0, m_thr, 8'd0};
                REG_SCRATCH: exp_rd = m_scratch;
                default: ;
            endcase
        end
        wc = 0;
        while (bus.avs_s0_waitrequest !== 1'b0 && wc < 8) begin
            @(negedge clk);
            wc++;
        end
        check("wait_len", 32'(wc), 32'd1);
        rdata = bus.avs_s0_readdata;
        if (rd) check($sformatf("rdata_a%0d", a), rdata, exp_rd);
        check("irq", 32'(irq), 32'(exp_irq));
        @(posedge clk);
        #1;
        bus.avs_s0_read  = 1'b0;
        bus.avs_s0_write = 1'b0;
        model_apply(rd, wr, a, wd);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("irq_idle", 32'(irq), 32'(exp_irq));
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset            = 1'b1;
        bus.avs_s0_read  = 1'b0;
        bus.avs_s0_write = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] rdv;
    logic [31:0] wdv;
    logic [1:0]  av;
    int          r;

    initial begin
        bus.avs_s0_address   = '0;
        bus.avs_s0_read      = 1'b0;
        bus.avs_s0_write     = 1'b0;
        bus.avs_s0_writedata = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("wait_in_reset", 32'(bus.avs_s0_waitrequest), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_readdata", bus.avs_s0_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_wait_idle", 32'(bus.avs_s0_waitrequest), 32'd0);

        xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);
        check("status_empty", rdv, 32'h0001_0000);

        // Fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) xfer(1'b0, 1'b1, REG_DATA, 32'h100 + 32'(i), rdv);
        xfer(1'b0, 1'b1, REG_DATA, 32'hDEAD, rdv);
        xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);
        check("status_full_ovf", rdv, 32'h0006_0010);
        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, 1'b0, REG_DATA, 32'd0, rdv);
            check("pop_order", rdv, 32'h100 + 32'(i));
        end
        xfer(1'b1, 1'b0, REG_DATA, 32'd0, rdv);
        check("pop_empty", rdv, 32'd0);
        xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);
        check("status_unf_ovf", rdv, 32'h000D_0000);

        // Flush and sticky clear with count 5
        for (int i = 0; i < 5; i++) xfer(1'b0, 1'b1, REG_DATA, $urandom, rdv);
        xfer(1'b0, 1'b1, REG_CTRL, 32'h0000_0003, rdv);
        xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);
        check("status_after_flush", rdv, 32'h0001_0000);
        xfer(1'b1, 1'b0, REG_CTRL, 32'd0, rdv);
        check("ctrl_thr_kept", rdv, 32'd0);

        // Interrupt threshold
        xfer(1'b0, 1'b1, REG_CTRL, 32'h0000_0400, rdv);
        for (int i = 0; i < 3; i++) xfer(1'b0, 1'b1, REG_DATA, $urandom, rdv);
        idle(2);
        check("irq_below_thr", 32'(irq), 32'd0);
        xfer(1'b0, 1'b1, REG_DATA, $urandom, rdv);
        @(negedge clk);
        check("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'd1);
        xfer(1'b1, 1'b0, REG_DATA, 32'd0, rdv);
        idle(2);
        check("irq_fall", 32'(irq), 32'd0);

        // Flush while full drops irq the following cycle
        while (mq.size() < int'(DEPTH)) xfer(1'b0, 1'b1, REG_DATA, $urandom, rdv);
        idle(2);
        check("irq_full", 32'(irq), 32'd1);
        xfer(1'b0, 1'b1, REG_CTRL, 32'h0000_0401, rdv);
        @(negedge clk);
        check("irq_flush_lag", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_flush_fall", 32'(irq), 32'd0);
        xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);

        // Reset asserted in the first cycle of a DATA write
        @(negedge clk);
        bus.avs_s0_address   = REG_DATA;
        bus.avs_s0_writedata = 32'h7777_0001;
        bus.avs_s0_write     = 1'b1;
        reset                = 1'b1;
        #1;
        check("wait_rst_T", 32'(bus.avs_s0_waitrequest), 32'd1);
        @(negedge clk);
        check("wait_rst_T1", 32'(bus.avs_s0_waitrequest), 32'd1);
        model_reset();
        @(negedge clk);
        check("wait_rst_T2", 32'(bus.avs_s0_waitrequest), 32'd1);
        bus.avs_s0_write = 1'b0;
        reset            = 1'b0;
        xfer(1'b0, 1'b1, REG_DATA, 32'h7777_0001, rdv);
        xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);
        check("status_reissue", rdv, 32'h0000_0001);
        xfer(1'b1, 1'b0, REG_DATA, 32'd0, rdv);
        check("reissue_data", rdv, 32'h7777_0001);

        // Scratch and simultaneous read+write on DATA
        xfer(1'b0, 1'b1, REG_SCRATCH, 32'hA5A5_5A5A, rdv);
        xfer(1'b1, 1'b0, REG_SCRATCH, 32'd0, rdv);
        check("scratch", rdv, 32'hA5A5_5A5A);
        xfer(1'b0, 1'b1, REG_DATA, 32'h0000_0A01, rdv);
        xfer(1'b0, 1'b1, REG_DATA, 32'h0000_0A02, rdv);
        xfer(1'b1, 1'b1, REG_DATA, 32'h0000_0BAD, rdv);
        check("rw_pop_head", rdv, 32'h0000_0A01);
        xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);
        check("rw_no_push", rdv, 32'h0000_0001);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            r   = int'($urandom_range(0, 99));
            wdv = $urandom;
            av  = 2'($urandom_range(0, 3));
            if (r < 38) begin
                xfer(1'b0, 1'b1, REG_DATA, wdv, rdv);
            end else if (r < 68) begin
                xfer(1'b1, 1'b0, REG_DATA, 32'd0, rdv);
            end else if (r < 76) begin
                xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);
            end else if (r < 82) begin
                wdv[15:8] = 8'($urandom_range(0, DEPTH + 2));
                wdv[0]    = ($urandom_range(0, 5) == 0);
                xfer(1'b0, 1'b1, REG_CTRL, wdv, rdv);
            end else if (r < 86) begin
                xfer(1'b1, 1'b0, REG_CTRL, 32'd0, rdv);
            end else if (r < 90) begin
                xfer(1'b0, 1'b1, av, wdv, rdv);
            end else if (r < 95) begin
                xfer(1'b1, 1'b1, av, wdv, rdv);
            end else begin
                idle(int'($urandom_range(1, 3)));
            end
        end
        xfer(1'b1, 1'b0, REG_STATUS, 32'd0, rdv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_mailbox_fifo.md
# avalon_mailbox_fifo

Avalon-MM slave peripheral attached to the system's exported `avalon_export_0_avs_s0` port (2-bit word address, 32-bit data, waitrequest). It provides a 32-bit mailbox FIFO that the system's master pushes and pops through four word registers. It also provides status, control and scratch registers, and a threshold interrupt to fabric logic. Every transfer completes in exactly two cycles using waitrequest.

## Interface
- `DEPTH`, default 16: FIFO entries. Power of two, 2..256.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `avs_s0_address` in 2: word address.
- `avs_s0_read` in 1: read request.
- `avs_s0_write` in 1: write request.
- `avs_s0_writedata` in 32: write data.
- `avs_s0_readdata` out 32: read data, registered. Valid when `read && !waitrequest`.
- `avs_s0_waitrequest` out 1: stall.
- `irq` out 1: registered level interrupt.

## Operation
Register map (word addresses):
- **0 DATA**
  - Write: pushes `writedata`. If the FIFO is full, the write is dropped and sticky `overflow` is set.
  - Read: returns the head entry and pops it. If the FIFO is empty, the read returns 0, sets sticky `underflow`, and pointers are unchanged.
- **1 STATUS** (RO; writes ignored):
  - [15:0] count
  - [16] empty
  - [17] full
  - [18] overflow
  - [19] underflow
  - [20] irq
  - others 0
- **2 CONTROL**
  - Write bit0=1: flush FIFO (count 0, pointers 0).
  - Write bit1=1: clear both sticky flags.
  - Bits [15:8]: threshold.
  - Read returns threshold in [15:8], 0 elsewhere (bits 0/1 are pulses).
- **3 SCRATCH**: 32-bit read/write, no side effects.

Interrupt:
- `irq` is registered: `irq <= (threshold != 0) && (count >= threshold)`.
- `irq` updates the cycle after the count changes.

Illegal cases:
- `read` and `write` both high: read is performed, write is ignored.
- Count saturates at DEPTH; count width is clog2(DEPTH)+1, zero-extended to 16 bits.

## Timing
Handshake:
- `waitrequest = reset | ((read | write) & !ack_q)`, combinational.
- Request first seen in cycle T:
  - `waitrequest` is high in T.
  - `ack_q` is set at the end of T; readdata is captured into `avs_s0_readdata` at the end of T.
  - In T+1, `waitrequest` is low and readdata is valid.
  - The side effect (push, pop, register write, flag set) commits at the end of T+1.
  - `ack_q` clears at the end of T+1.
- Back-to-back requests: the next request starts at T+2, so 2 cycles per transfer.
- The master holds address, data and strobes stable while `waitrequest` is high.
- A STATUS read returns the state before its own transfer. A DATA read following a push at T+1 sees that entry.

Reset values:
- `ack_q` 0.
- `readdata` 0.
- `irq` 0.
- FIFO empty, pointers 0.
- Flags 0, threshold 0, scratch 0.
- `waitrequest` is 1 while `reset` is high.

Boundary conditions:
- Reset asserted mid-transfer: the transfer is aborted with no side effect, and the master re-issues it.
- Pointer wrap: modulo DEPTH. full means count == DEPTH.
- Flush while full: count goes to 0 and `irq` falls the next cycle.
- Sticky-clear and a new overflow cannot coincide (single port).

## Structure
- Package `avalon_mailbox_pkg` holds:
  - Register address localparams `REG_DATA=0`, `REG_STATUS=1`, `REG_CTRL=2`, `REG_SCRATCH=3`.
  - STATUS bit positions.
  - CONTROL bit positions and the threshold field range.
- Sub-module `sync_fifo`:
  - Parameterised DEPTH x 32 storage, read/write pointers, count.
  - push/pop/flush inputs; full/empty/count outputs; show-ahead head data.
  - Ignores push when full and pop when empty.
- The top level holds:
  - the Avalon handshake (`ack_q`),
  - register decode,
  - sticky flags,
  - `irq`.

## Test plan
- **Reset, then single transfer:** read STATUS → `waitrequest` high 1 cycle, then readdata=0x0001_0000 (empty).
- **Fill, overflow, drain:** with DEPTH=16, push 0x100..0x10F, then push 0xDEAD → STATUS=0x0006_0010 (full|overflow, count 16). Pop 16 times → data in order 0x100..0x10F. Then a 17th pop → data 0, underflow set.
- **Interrupt threshold:** write CONTROL=0x0000_0400, then push 3 entries → irq low. Push a 4th → irq high the cycle after commit. Pop 1 → irq low.
- **Flush and sticky clear:** with flags set and count 5, write CONTROL=0x3 → STATUS reads 0x0001_0000, threshold unchanged.
- **Reset mid-transfer:** assert `reset` in cycle T of a DATA write → no push. `waitrequest` stays high during reset. The re-issued write after reset completes with count 1.
- **Back-to-back alternating traffic and scratch:** write SCRATCH=0xA5A5_5A5A, then read it → 0xA5A5_5A5A. Hold `read` and `write` both high on DATA with 2 entries → head popped, no push.
